// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types, default 640x480@60 timing and total-length helpers.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Largest axis length a coord_t counter can cover.
  localparam int COORD_LIMIT  = 1024;

  typedef logic [9:0] coord_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active and
// active-low sync flags derived from the next count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   step_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   active_o,
  output logic   sync_n_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > COORD_LIMIT) begin : g_total_chk
    $error("vga_axis_counter: axis total exceeds 1024");
  end

  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END    = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  coord_t count_q, count_d;
  logic   active_q, active_d;
  logic   sync_n_q, sync_n_d;

  always_comb begin
    wrap_o  = step_i && (count_q == LAST);
    count_d = count_q;
    if (step_i) begin
      count_d = wrap_o ? '0 : count_q + coord_t'(1);
    end
    // Flags follow the next count so they line up with count_q after the edge.
    active_d = (count_d < ACT_END);
    sync_n_d = !((count_d >= SYNC_START) && (count_d < SYNC_END));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      active_q <= 1'b1;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = active_q;
  assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: Col/Row, display_on, HSYNC/VSYNC and line/frame
// strobes. Optional frame counter output enabled by VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       pix_en,
  output logic [9:0] Col,
  output logic [9:0] Row,
  output logic       display_on,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       line_tick,
`ifdef VGA_FRAME_CNT_EN
  output logic       frame_tick,
  output logic [7:0] frame_cnt
`else
  output logic       frame_tick
`endif
);

  localparam coord_t LAST_ACTIVE_ROW = coord_t'(V_ACTIVE - 1);

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;
  logic   h_active, v_active;
  logic   h_sync_n, v_sync_n;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .step_i   (pix_en),
    .count_o  (h_count),
    .wrap_o   (h_wrap),
    .active_o (h_active),
    .sync_n_o (h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .step_i   (h_wrap),
    .count_o  (v_count),
    .wrap_o   (v_wrap),
    .active_o (v_active),
    .sync_n_o (v_sync_n)
  );

  logic line_tick_q, line_tick_d;
  logic frame_tick_q, frame_tick_d;

  // The full-frame wrap back to row 0 is never a frame strobe, even when
  // the vertical blanking length is zero.
  always_comb begin
    line_tick_d  = h_wrap;
    frame_tick_d = h_wrap && (v_count == LAST_ACTIVE_ROW) && !v_wrap;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign Col        = h_count;
  assign Row        = v_count;
  assign display_on = h_active && v_active;
  assign HSYNC      = h_sync_n;
  assign VSYNC      = v_sync_n;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line
// timing and a shrunken-timing instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Default-timing instance
  logic       rst_n, pix_en;
  logic [9:0] col, row;
  logic       disp, hs, vs, ltick, ftick;

  // Small-timing instance: H 8/2/3/2 (total 15), V 6/2/2/2 (total 12)
  logic       rst_n_s, pix_en_s;
  logic [9:0] col_s, row_s;
  logic       disp_s, hs_s, vs_s, ltick_s, ftick_s;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt, fcnt_s;
`endif

  vga_timing_gen u_dut (
    .CLK        (CLK),
    .RST_N      (rst_n),
    .pix_en     (pix_en),
    .Col        (col),
    .Row        (row),
    .display_on (disp),
    .HSYNC      (hs),
    .VSYNC      (vs),
    .line_tick  (ltick),
`ifdef VGA_FRAME_CNT_EN
    .frame_tick (ftick),
    .frame_cnt  (fcnt)
`else
    .frame_tick (ftick)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_small (
    .CLK        (CLK),
    .RST_N      (rst_n_s),
    .pix_en     (pix_en_s),
    .Col        (col_s),
    .Row        (row_s),
    .display_on (disp_s),
    .HSYNC      (hs_s),
    .VSYNC      (vs_s),
    .line_tick  (ltick_s),
`ifdef VGA_FRAME_CNT_EN
    .frame_tick (ftick_s),
    .frame_cnt  (fcnt_s)
`else
    .frame_tick (ftick_s)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int bad_col, bad_row, hs_low, hs_first, hs_last, disp_cnt;
    int lt_cnt, lt_col, lt_row;
    int mc, mr, bad_lvl, ft_cnt, ft_col, ft_row, vs_low, ltk_cnt;
    logic exp_hs, exp_vs, exp_disp;

    rst_n = 1'b0; pix_en = 1'b1;
    rst_n_s = 1'b0; pix_en_s = 1'b1;
    tick(); tick();

    // Reset state, default instance
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_disp", disp, 1);
    chk("rst_hsync", hs, 1);
    chk("rst_vsync", vs, 1);
    chk("rst_ltick", ltick, 0);
    chk("rst_ftick", ftick, 0);

    // One full line at default timing
    rst_n = 1'b1;
    bad_col = 0; bad_row = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    disp_cnt = 0; lt_cnt = 0; lt_col = -1; lt_row = -1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (col !== 10'(k % 800)) bad_col++;
      if (row !== 10'(k / 800)) bad_row++;
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(col);
        hs_last = int'(col);
      end
      if (disp === 1'b1) disp_cnt++;
      if (ltick === 1'b1) begin
        lt_cnt++;
        lt_col = int'(col);
        lt_row = int'(row);
      end
    end
    chk("line_col_seq_errs", bad_col, 0);
    chk("line_row_seq_errs", bad_row, 0);
    chk("line_end_col", col, 0);
    chk("line_end_row", row, 1);
    chk("hsync_low_cycles", hs_low, 96);
    chk("hsync_first_col", hs_first, 656);
    chk("hsync_last_col", hs_last, 751);
    chk("line_disp_cycles", disp_cnt, 640);
    chk("ltick_count", lt_cnt, 1);
    chk("ltick_col", lt_col, 0);
    chk("ltick_row", lt_row, 1);

    // Full frame on the small instance, checked against a reference raster
    rst_n_s = 1'b1;
    mc = 0; mr = 0; bad_lvl = 0; ft_cnt = 0; ft_col = -1; ft_row = -1;
    vs_low = 0; disp_cnt = 0; ltk_cnt = 0; bad_col = 0;
    for (int k = 1; k <= 180; k++) begin
      tick();
      if (mc == 14) begin
        mc = 0;
        mr = (mr == 11) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
      exp_hs   = !(mc >= 10 && mc <= 12);
      exp_vs   = !(mr >= 8 && mr <= 9);
      exp_disp = (mc < 8) && (mr < 6);
      if (col_s !== 10'(mc) || row_s !== 10'(mr)) bad_col++;
      if (hs_s !== exp_hs || vs_s !== exp_vs || disp_s !== exp_disp) bad_lvl++;
      if (ltick_s !== (mc == 0)) bad_lvl++;
      if (ftick_s === 1'b1) begin
        ft_cnt++;
        ft_col = int'(col_s);
        ft_row = int'(row_s);
      end
      if (vs_s === 1'b0) vs_low++;
      if (disp_s === 1'b1) disp_cnt++;
      if (ltick_s === 1'b1) ltk_cnt++;
    end
    chk("frame_pos_errs", bad_col, 0);
    chk("frame_level_errs", bad_lvl, 0);
    chk("ftick_count", ft_cnt, 1);
    chk("ftick_col", ft_col, 0);
    chk("ftick_row", ft_row, 6);
    chk("vsync_low_cycles", vs_low, 30);
    chk("frame_disp_cycles", disp_cnt, 48);
    chk("frame_ltick_count", ltk_cnt, 12);

    // State right after the full wrap (14,11)->(0,0)
    chk("wrap_col", col_s, 0);
    chk("wrap_row", row_s, 0);
    chk("wrap_ltick", ltick_s, 1);
    chk("wrap_ftick", ftick_s, 0);
    chk("wrap_vsync", vs_s, 1);
    chk("wrap_disp", disp_s, 1);

    // Walk to (14,5), then alternate pix_en across the frame strobe
    for (int k = 0; k < 89; k++) tick();
    chk("pre_tog_col", col_s, 14);
    chk("pre_tog_row", row_s, 5);
    pix_en_s = 1'b1; tick();
    chk("tog1_col", col_s, 0);
    chk("tog1_row", row_s, 6);
    chk("tog1_ltick", ltick_s, 1);
    chk("tog1_ftick", ftick_s, 1);
    chk("tog1_disp", disp_s, 0);
    pix_en_s = 1'b0; tick();
    chk("tog0_col", col_s, 0);
    chk("tog0_row", row_s, 6);
    chk("tog0_ltick", ltick_s, 0);
    chk("tog0_ftick", ftick_s, 0);
    pix_en_s = 1'b1; tick();
    chk("tog2_col", col_s, 1);
    chk("tog2_ltick", ltick_s, 0);
    chk("tog2_ftick", ftick_s, 0);
    pix_en_s = 1'b0; tick();
    chk("tog3_col", col_s, 1);

    // Mid-frame reset while both syncs are low at (11,8)
    pix_en_s = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("pre_rst_col", col_s, 11);
    chk("pre_rst_row", row_s, 8);
    chk("pre_rst_hsync", hs_s, 0);
    chk("pre_rst_vsync", vs_s, 0);
    chk("pre_rst_disp", disp_s, 0);
    rst_n_s = 1'b0; tick();
    chk("mid_rst_col", col_s, 0);
    chk("mid_rst_row", row_s, 0);
    chk("mid_rst_hsync", hs_s, 1);
    chk("mid_rst_vsync", vs_s, 1);
    chk("mid_rst_disp", disp_s, 1);
    chk("mid_rst_ltick", ltick_s, 0);
    chk("mid_rst_ftick", ftick_s, 0);
    rst_n_s = 1'b1; tick();
    chk("post_rst_col", col_s, 1);
    chk("post_rst_row", row_s, 0);

`ifdef VGA_FRAME_CNT_EN
    // Re-enter reset to start frame counting from a clean frame
    rst_n_s = 1'b0; tick();
    chk("fcnt_rst", fcnt_s, 0);
    rst_n_s = 1'b1;
    for (int k = 0; k < 179; k++) tick();
    chk("fcnt_one_frame", fcnt_s, 1);
    for (int k = 0; k < 256 * 180; k++) tick();
    chk("fcnt_after_257", fcnt_s, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the 640x480 VGA display path. It drives the Row/Col/display_on interface that the pattern generators consume, plus the HSYNC/VSYNC pins.
- Also emits one-cycle line_tick and frame_tick strobes. Downstream animation logic must clock-enable on frame_tick rather than deriving a clock from Row.
- Sits between the PLL/pixel-clock domain and patterngen.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
pix_en  in  1  pixel advance enable; counters step only on CLK edges with pix_en=1 (tie high when CLK is the pixel clock)
Col  out  10  horizontal position, 0..H_TOTAL-1
Row  out  10  vertical position, 0..V_TOTAL-1
display_on  out  1  high when Col<H_ACTIVE and Row<V_ACTIVE
HSYNC  out  1  active-low horizontal sync
VSYNC  out  1  active-low vertical sync
line_tick  out  1  one-CLK pulse on entry to Col=0
frame_tick  out  1  one-CLK pulse on entry to (Col=0, Row=V_ACTIVE)

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be <=1024; elaboration-time assertion otherwise.
- Reset (RST_N=0 at a CLK edge): Col=0, Row=0, display_on=1, HSYNC=1, VSYNC=1, line_tick=0, frame_tick=0. Reset mid-frame aborts the frame immediately; no partial line completes.
- Counter advance on a CLK edge with pix_en=1:
  - If Col=H_TOTAL-1: Col<=0 and Row advances.
  - Otherwise Col<=Col+1.
  - Row advance: if Row=V_TOTAL-1 then Row<=0, otherwise Row<=Row+1.
- With pix_en=0, all counters and level outputs hold; line_tick and frame_tick are 0.
- HSYNC=0 iff H_ACTIVE+H_FP <= Col <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- VSYNC=0 iff V_ACTIVE+V_FP <= Row <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- Alignment: display_on, HSYNC and VSYNC are registered, computed from next-state counter values. They are always consistent with the Col/Row visible in the same cycle, with zero added latency and no combinational path from counters to pins.
- line_tick: high for exactly the CLK cycle after a pix_en advance that wraps Col to 0. Otherwise 0.
- frame_tick: high for exactly the CLK cycle after a pix_en advance into (Col=0, Row=V_ACTIVE), i.e. the first blanking line. It fires once per frame, and line_tick fires in the same cycle.
- Full wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0): line_tick=1, frame_tick=0.
- Consecutive pix_en advances give strobes exactly 1 cycle wide; a stalled pix_en never stretches a strobe.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt [7:0]. It resets to 0, increments in the same cycle frame_tick is asserted, and wraps 255->0. Used for sprite animation/scroll phase.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default localparams for the 640x480@60 timing values;
  - derived H_TOTAL/V_TOTAL functions;
  - typedef logic [9:0] coord_t, used for Row/Col here and in patterngen.
- Sub-module vga_axis_counter, instanced twice (horizontal and vertical):
  - parameters: ACTIVE/FP/SYNC/BP;
  - inputs: step enable;
  - outputs: registered count, wrap strobe, active flag, sync_n.

Test Plan:
- Reset, then pix_en=1 for 800 cycles -> Col runs 0..799 then 0; Row goes 0->1; line_tick pulses once at Col=0,Row=1; HSYNC low exactly for Col 656..751 (96 cycles).
- Run a full frame of 420000 cycles -> frame_tick pulses once at (0,480); VSYNC low for Rows 490..491 (1600 cycles); display_on high for 307200 cycles.
- pix_en toggling 1,0,1,0 -> counters advance every other cycle; at (799,479)->(0,480) the frame_tick and line_tick pulses stay 1 cycle wide and drop during the pix_en=0 cycle.
- Assert RST_N=0 for one cycle at (700,300) -> next cycle Col=0, Row=0, HSYNC=1, VSYNC=1, display_on=1, no tick.
- Wrap (799,524)->(0,0) -> line_tick=1, frame_tick=0, VSYNC=1, display_on=1.
- With VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt reads 1 after the wrap (255->0->1).
